// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and bit-order constant for the serializer
package ser_pkg;

    typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;

    localparam bit SER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/ser_hold_buf.sv
// rtl/ser_hold_buf.sv - one-word hold register with valid flag for the skid path
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Write wins over read; the serializer never issues both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_data  <= i_wr_data;
            r_valid <= 1'b1;
        end else if (i_rd) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - valid/ready word in, one bit per ser_en out, MSB first
// Optional SER_SKID_EN adds a one-word hold buffer so consecutive words stream without a bubble.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);
    import ser_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;

    logic             w_shift_st;
    logic             w_xfer;
    logic             w_last;
    logic             w_accept;
    logic             w_cur_bit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_reload;
    logic [WIDTH-1:0] w_reload_word;

    assign w_shift_st = (r_state == SER_SHIFT);
    assign w_xfer     = w_shift_st && ser_en;
    assign w_last     = w_xfer && (r_cnt == '0);
    assign w_accept   = din_valid && din_ready;
    assign w_cur_bit  = SER_MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign w_shifted  = SER_MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

`ifdef SER_SKID_EN
    logic             w_hold_valid;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_wr;
    logic             w_hold_rd;

    // On the LSB transfer a fresh din goes straight to sreg, so only mid-word handshakes are parked.
    assign w_hold_wr     = w_accept && w_shift_st && !w_last;
    assign w_hold_rd     = w_last && w_hold_valid;
    assign w_reload      = w_last && (w_hold_valid || din_valid);
    assign w_reload_word = w_hold_valid ? w_hold_data : din;
    assign din_ready     = !w_shift_st || !w_hold_valid;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (w_hold_wr),
        .i_wr_data (din),
        .i_rd      (w_hold_rd),
        .o_data    (w_hold_data),
        .o_valid   (w_hold_valid)
    );
`else
    assign w_reload      = 1'b0;
    assign w_reload_word = din;
    assign din_ready     = !w_shift_st;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SER_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (w_accept) begin
                        r_sreg  <= din;
                        r_cnt   <= CNT_LAST;
                        r_state <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    if (w_xfer) begin
                        if (r_cnt != '0) begin
                            r_sreg <= w_shifted;
                            r_cnt  <= r_cnt - 1'b1;
                        end else if (w_reload) begin
                            r_sreg <= w_reload_word;
                            r_cnt  <= CNT_LAST;
                        end else begin
                            r_sreg  <= w_shifted;
                            r_state <= SER_IDLE;
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign ser_valid = w_shift_st;
    assign ser_out   = w_shift_st && w_cur_bit;
    assign word_done = w_last;
    assign busy      = w_shift_st;

endmodule
